ahb_sram_slave: RTL and testbench

// AHB-Lite slave (responder) fronting a 32-bit single-port synchronous SRAM; the far end of the
// CPU data master port (SRAM region) on the bus matrix. Zero-wait reads and writes via a one-entry

---
 rtl/ahb_sram_slave.sv | 154 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a 32-bit single-port synchronous SRAM.
// Reads and writes complete with zero wait states. Writes go through a one-entry buffer with
// read forwarding. Illegal transfers get a two-cycle ERROR response.
module ahb_sram_slave #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned MEM_WORDS  = 16384
) (
   input  logic                  cpu_hclk,
   input  logic                  cpu_hrst_n,
   input  logic                  hsel,
   input  logic [31:0]           haddr,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hsize,
   input  logic                  hwrite,
   input  logic [31:0]           hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [31:0]           hrdata,
   output logic                  sram_cs,
   output logic [3:0]            sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_t;

   state_t                r_state;
   logic                  r_wr_pend;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [3:0]            r_wr_strb;
   logic                  r_rd_pend;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_buf_valid;
   logic [ADDR_WIDTH-1:0] r_buf_addr;
   logic [3:0]            r_buf_strb;
   logic [31:0]           r_buf_data;

   logic [ADDR_WIDTH-1:0] w_word_idx;
   logic [31:0]           w_idx_ext;
   logic [3:0]            w_strb;
   logic                  w_illegal;
   logic                  w_accept;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_conflict;
   logic                  w_hreadyout;
   logic                  w_wr_done;
   logic                  w_drain;
   logic                  w_unused_bits;

   assign w_unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

   assign w_word_idx = haddr[ADDR_WIDTH+1:2];
   assign w_idx_ext  = 32'(w_word_idx);
   assign w_illegal  = (hsize > 3'd2)
                     | ((hsize == 3'd1) & haddr[0])
                     | ((hsize == 3'd2) & (|haddr[1:0]))
                     | (w_idx_ext >= MEM_WORDS);

   // A read address arriving while a buffered write is still waiting and another write is in its
   // data phase would need the buffer to hold two entries; stall one cycle to drain it instead.
   assign w_conflict  = r_buf_valid & r_wr_pend & hsel & htrans[1] & ~hwrite;
   assign w_hreadyout = (r_state != StErr1) & ~w_conflict;
   assign hreadyout   = w_hreadyout;
   assign hresp       = (r_state == StIdle) ? 2'b00 : 2'b01;

   assign w_accept  = hsel & htrans[1] & hready & w_hreadyout;
   assign w_rd_acc  = w_accept & ~w_illegal & ~hwrite;
   assign w_wr_acc  = w_accept & ~w_illegal & hwrite;
   assign w_wr_done = r_wr_pend & w_hreadyout;
   assign w_drain   = r_buf_valid & ~w_rd_acc;

   // Byte lane strobes for the transfer in its address phase
   always_comb begin
      w_strb = 4'b1111;
      case (hsize)
         3'd0:    w_strb = 4'b0001 << haddr[1:0];
         3'd1:    w_strb = haddr[1] ? 4'b1100 : 4'b0011;
         default: w_strb = 4'b1111;
      endcase
   end

   // SRAM port: an accepted read owns the port, otherwise the buffer drains
   always_comb begin
      sram_cs    = w_rd_acc | r_buf_valid;
      sram_we    = w_rd_acc ? 4'b0000 : (r_buf_valid ? r_buf_strb : 4'b0000);
      sram_addr  = w_rd_acc ? w_word_idx : r_buf_addr;
      sram_wdata = r_buf_data;
   end

   // Read data with byte-wise forwarding from a buffered write to the same word
   always_comb begin
      hrdata = '0;
      if (r_rd_pend) begin
         hrdata = sram_rdata;
         if (r_buf_valid && (r_buf_addr == r_rd_addr)) begin
            for (int b = 0; b < 4; b++) begin
               if (r_buf_strb[b]) hrdata[8*b +: 8] = r_buf_data[8*b +: 8];
            end
         end
      end
   end

   // Response FSM; ERR2 accepts a new transfer exactly like IDLE
   always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
      if (!cpu_hrst_n) begin
         r_state <= StIdle;
      end else begin
         case (r_state)
            StErr1:  r_state <= StErr2;
            default: r_state <= (w_accept && w_illegal) ? StErr1 : StIdle;
         endcase
      end
   end

   // Data-phase tracking; held while this slave inserts a wait state
   always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
      if (!cpu_hrst_n) begin
         r_wr_pend <= 1'b0;
         r_wr_addr <= '0;
         r_wr_strb <= '0;
         r_rd_pend <= 1'b0;
         r_rd_addr <= '0;
      end else if (w_hreadyout) begin
         r_wr_pend <= w_wr_acc;
         r_rd_pend <= w_rd_acc;
         if (w_wr_acc) begin
            r_wr_addr <= w_word_idx;
            r_wr_strb <= w_strb;
         end
         if (w_rd_acc) r_rd_addr <= w_word_idx;
      end
   end

   // Write buffer: a new entry takes priority over a drain in the same cycle
   always_ff @(posedge cpu_hclk or negedge cpu_hrst_n) begin
      if (!cpu_hrst_n) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_strb  <= '0;
         r_buf_data  <= '0;
      end else if (w_wr_done) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= r_wr_addr;
         r_buf_strb  <= r_wr_strb;
         r_buf_data  <= hwdata;
      end else if (w_drain) begin
         r_buf_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed AHB beats, a behavioural SRAM, and
// scoreboards for bus responses and SRAM writes.
module tb_ahb_sram_slave;
   localparam int unsigned AW = 14;
   localparam int unsigned MW = 16000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hsel = 1'b0;
   logic [31:0]   haddr = '0;
   logic [1:0]    htrans = '0;
   logic [2:0]    hsize = '0;
   logic          hwrite = 1'b0;
   logic [31:0]   hwdata = '0;
   logic          hready;
   logic          hreadyout;
   logic [1:0]    hresp;
   logic [31:0]   hrdata;
   logic          sram_cs;
   logic [3:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata = '0;
   logic [31:0]   mem [0:(1<<AW)-1] = '{default: '0};

   int checks = 0;
   int failures = 0;
   int rd_count = 0;

   typedef struct {
      bit          wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  resp;
      int          waits;
      logic [31:0] rdata;
      logic [3:0]  dwe;
   } beat_t;
   typedef struct {
      string       name;
      logic [1:0]  resp;
      int          waits;
      logic [31:0] rdata;
   } exp_t;
   typedef struct {
      string         name;
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [31:0]   data;
   } wexp_t;

   exp_t  expq[$];
   wexp_t wq[$];

   always #5 clk = ~clk;
   assign hready = hreadyout;

   ahb_sram_slave #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
      .cpu_hclk(clk), .cpu_hrst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
      .hresp(hresp), .hrdata(hrdata), .sram_cs(sram_cs), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // Behavioural synchronous SRAM
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we == 4'b0000) sram_rdata <= mem[sram_addr];
         else begin
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic beat_t mk(bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                                logic [1:0] resp, int waits, logic [31:0] rd, logic [3:0] dwe);
      beat_t b;
      b.wr = wr; b.size = sz; b.addr = a; b.wdata = wd;
      b.resp = resp; b.waits = waits; b.rdata = rd; b.dwe = dwe;
      return b;
   endfunction

   task automatic idle(input int n);
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0; hwdata = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive beats back-to-back with AHB pipelining, followed by one IDLE address phase
   task automatic run_seq(input beat_t seq[$], input string tag);
      logic [31:0] wd = '0;
      int n;
      for (int i = 0; i <= seq.size(); i++) begin
         if (i < seq.size()) begin
            hsel = 1'b1; htrans = 2'b10; hwrite = seq[i].wr;
            hsize = seq[i].size; haddr = seq[i].addr;
            expq.push_back('{$sformatf("%s[%0d]", tag, i), seq[i].resp, seq[i].waits,
                             seq[i].rdata});
            if (seq[i].wr && seq[i].dwe != 4'b0000)
               wq.push_back('{$sformatf("%s_drain[%0d]", tag, i), seq[i].addr[AW+1:2],
                              seq[i].dwe, seq[i].wdata});
         end else begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
         end
         hwdata = wd;
         n = 0;
         forever begin
            @(negedge clk);
            if (hreadyout) break;
            n++;
            if (n > 8) begin
               checks++; failures++;
               $display("FAIL %s_ready_timeout actual=%0d required<=8", tag, n);
               break;
            end
         end
         @(posedge clk);
         #1;
         wd = (i < seq.size() && seq[i].wr) ? seq[i].wdata : 32'h0;
      end
      hwdata = '0;
   endtask

   // Bus response monitor
   initial begin
      bit         dp = 1'b0;
      int         w = 0;
      logic [1:0] wresp = '0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dp = 1'b0; w = 0;
         end else begin
            if (dp) begin
               if (!hreadyout) begin
                  w++; wresp = hresp;
               end else begin
                  if (expq.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_completion actual=resp%0d required=none", hresp);
                  end else begin
                     e = expq.pop_front();
                     chk({e.name, ".resp"}, 32'(hresp), 32'(e.resp));
                     chk({e.name, ".waits"}, w, e.waits);
                     chk({e.name, ".rdata"}, hrdata, e.rdata);
                     if (w > 0) chk({e.name, ".wait_resp"}, 32'(wresp), 32'(e.resp));
                  end
                  dp = 1'b0; w = 0;
               end
            end
            if (hsel && htrans[1] && hready) dp = 1'b1;
         end
      end
   end

   // SRAM access monitor
   initial begin
      wexp_t x;
      logic [31:0] m;
      forever begin
         @(negedge clk);
         if (rst_n && sram_cs) begin
            if (sram_we == 4'b0000) rd_count++;
            else if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_sram_write actual=addr%h we%b required=none",
                        sram_addr, sram_we);
            end else begin
               x = wq.pop_front();
               m = {{8{x.we[3]}}, {8{x.we[2]}}, {8{x.we[1]}}, {8{x.we[0]}}};
               chk({x.name, ".addr"}, 32'(sram_addr), 32'(x.addr));
               chk({x.name, ".we"}, 32'(sram_we), 32'(x.we));
               chk({x.name, ".data"}, sram_wdata & m, x.data & m);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      beat_t s[$];
      #1;
      chk("rst.hreadyout", 32'(hreadyout), 32'd1);
      chk("rst.hresp", 32'(hresp), 32'd0);
      chk("rst.hrdata", hrdata, 32'h0);
      chk("rst.sram_cs", 32'(sram_cs), 32'd0);
      chk("rst.sram_we", 32'(sram_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Word write, then drain on the cycle after its data phase
      s = {};
      s.push_back(mk(1, 3'd2, 32'h10, 32'hDEADBEEF, 2'b00, 0, 32'h0, 4'hF));
      run_seq(s, "wr_drain");
      chk("wr_drain.cs", 32'(sram_cs), 32'd1);
      chk("wr_drain.we", 32'(sram_we), 32'hF);
      chk("wr_drain.addr", 32'(sram_addr), 32'd4);
      chk("wr_drain.hresp", 32'(hresp), 32'd0);
      idle(3);

      // Write then read of the same word, back to back
      s = {};
      s.push_back(mk(1, 3'd2, 32'h10, 32'h11223344, 2'b00, 0, 32'h0, 4'hF));
      s.push_back(mk(0, 3'd2, 32'h10, 32'h0, 2'b00, 0, 32'h11223344, 4'h0));
      run_seq(s, "wr_rd");
      idle(3);

      // Byte write forwarded into a word read
      s = {};
      s.push_back(mk(1, 3'd0, 32'h13, 32'hAA000000, 2'b00, 0, 32'h0, 4'h8));
      s.push_back(mk(0, 3'd2, 32'h10, 32'h0, 2'b00, 0, 32'hAA223344, 4'h0));
      run_seq(s, "byte_fwd");
      idle(3);

      // Two writes then a read: one stall cycle on the second write's data phase
      s = {};
      s.push_back(mk(1, 3'd2, 32'h20, 32'hA1A2A3A4, 2'b00, 0, 32'h0, 4'hF));
      s.push_back(mk(1, 3'd2, 32'h24, 32'hB1B2B3B4, 2'b00, 1, 32'h0, 4'hF));
      s.push_back(mk(0, 3'd2, 32'h20, 32'h0, 2'b00, 0, 32'hA1A2A3A4, 4'h0));
      run_seq(s, "stall");
      idle(3);

      // Illegal transfers, back-to-back errors, legal beats accepted in ERR2, range boundary
      s = {};
      s.push_back(mk(0, 3'd2, 32'h02, 32'h0, 2'b01, 1, 32'h0, 4'h0));
      s.push_back(mk(0, 3'd3, 32'h40, 32'h0, 2'b01, 1, 32'h0, 4'h0));
      s.push_back(mk(0, 3'd2, 32'h10, 32'h0, 2'b00, 0, 32'hAA223344, 4'h0));
      s.push_back(mk(1, 3'd1, 32'h41, 32'h12345678, 2'b01, 1, 32'h0, 4'h0));
      s.push_back(mk(0, 3'd2, 32'hFA00, 32'h0, 2'b01, 1, 32'h0, 4'h0));
      s.push_back(mk(0, 3'd2, 32'hF9FC, 32'h0, 2'b00, 0, 32'h0, 4'h0));
      s.push_back(mk(0, 3'd0, 32'h11, 32'h0, 2'b00, 0, 32'hAA223344, 4'h0));
      run_seq(s, "err");
      idle(3);

      // Halfword and byte partial forwarding
      s = {};
      s.push_back(mk(1, 3'd1, 32'h16, 32'h55660000, 2'b00, 0, 32'h0, 4'hC));
      s.push_back(mk(0, 3'd2, 32'h14, 32'h0, 2'b00, 0, 32'h55660000, 4'h0));
      s.push_back(mk(1, 3'd0, 32'h15, 32'h00007700, 2'b00, 0, 32'h0, 4'h2));
      s.push_back(mk(0, 3'd2, 32'h14, 32'h0, 2'b00, 0, 32'h55667700, 4'h0));
      run_seq(s, "half");
      idle(3);

      // Reset with a buffered write: it must never reach the SRAM
      s = {};
      s.push_back(mk(1, 3'd2, 32'h30, 32'hCAFEF00D, 2'b00, 0, 32'h0, 4'h0));
      run_seq(s, "rst_buf");
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid.hreadyout", 32'(hreadyout), 32'd1);
      chk("rst_mid.hresp", 32'(hresp), 32'd0);
      chk("rst_mid.sram_cs", 32'(sram_cs), 32'd0);
      chk("rst_mid.sram_we", 32'(sram_we), 32'd0);
      chk("rst_mid.hrdata", hrdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      s = {};
      s.push_back(mk(0, 3'd2, 32'h30, 32'h0, 2'b00, 0, 32'h0, 4'h0));
      run_seq(s, "rst_rd");
      idle(4);

      chk("end.resp_queue_empty", expq.size(), 0);
      chk("end.write_queue_empty", wq.size(), 0);
      chk("end.sram_read_count", rd_count, 9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
